// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
// Holds the FSM state encoding and the port index names used by the top and sub-module.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_e;

  localparam logic PORT_MEM = 1'b0;
  localparam logic PORT_AUX = 1'b1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of requester, status and memory-side signals around the data-memory arbiter.
// The slave modport is the arbiter's view; master is the view of the requesters and memory model.
interface dmem_arbiter_if #(
  parameter int WORD_SIZE = 32
);
  logic                 p0_req;
  logic                 p0_we;
  logic [WORD_SIZE-1:0] p0_addr;
  logic [WORD_SIZE-1:0] p0_wdata;
  logic                 p0_ready;
  logic [WORD_SIZE-1:0] p0_rdata;

  logic                 p1_req;
  logic                 p1_we;
  logic [WORD_SIZE-1:0] p1_addr;
  logic [WORD_SIZE-1:0] p1_wdata;
  logic                 p1_ready;
  logic [WORD_SIZE-1:0] p1_rdata;

  logic                 stall;
  logic                 busy;

  logic                 mem_read;
  logic                 mem_write;
  logic [WORD_SIZE-1:0] mem_addr;
  logic [WORD_SIZE-1:0] mem_wdata;
  logic [WORD_SIZE-1:0] mem_rdata;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    input  mem_rdata,
    output p0_ready, p0_rdata, p1_ready, p1_rdata,
    output stall, busy,
    output mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    output mem_rdata,
    input  p0_ready, p0_rdata, p1_ready, p1_rdata,
    input  stall, busy,
    input  mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter_rr_arbiter2.sv
// Combinational two-requester round-robin grant.
// A lone requester always wins; on a tie the port that did not win last time is chosen.
module rr_arbiter2 (
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  output logic       o_gnt_valid,
  output logic       o_gnt_idx
);

  assign o_gnt_valid = |i_req;
  assign o_gnt_idx   = (i_req == 2'b11) ? ~i_last_grant : i_req[1];

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port controller for the single-ported data memory: round-robin grant, latched request,
// fixed-latency access counted by a wait-state counter, and a one-cycle ready pulse per port.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int WORD_SIZE   = 32,
  parameter int WAIT_STATES = 1,
  parameter int CNT_W       = 4
) (
  input  logic            clk,
  input  logic            rst,
  dmem_arbiter_if.slave   bus
);

  state_e               r_state;
  state_e               w_next_state;
  logic                 r_sel;
  logic                 r_we;
  logic                 r_last_grant;
  logic [WORD_SIZE-1:0] r_addr;
  logic [WORD_SIZE-1:0] r_wdata;
  logic [WORD_SIZE-1:0] r_p0_rdata;
  logic [WORD_SIZE-1:0] r_p1_rdata;
  logic [CNT_W-1:0]     r_cnt;

  logic w_gnt_valid;
  logic w_gnt_idx;
  logic w_cnt_zero;
  logic w_mem_read;
  logic w_mem_write;
  logic w_p0_ready;
  logic w_p1_ready;

  rr_arbiter2 u_rr (
    .i_req        ({bus.p1_req, bus.p0_req}),
    .i_last_grant (r_last_grant),
    .o_gnt_valid  (w_gnt_valid),
    .o_gnt_idx    (w_gnt_idx)
  );

  assign w_cnt_zero = (r_cnt == '0);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    w_next_state = r_state;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_p0_ready   = 1'b0;
    w_p1_ready   = 1'b0;
    case (r_state)
      IDLE: if (w_gnt_valid) w_next_state = ACCESS;
      ACCESS: begin
        w_mem_read  = ~r_we;
        w_mem_write = r_we & w_cnt_zero;
        if (w_cnt_zero) w_next_state = RESP;
      end
      RESP: begin
        w_p0_ready   = (r_sel == PORT_MEM);
        w_p1_ready   = (r_sel == PORT_AUX);
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // last_grant resets to the aux port so the MEM stage wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel        <= PORT_MEM;
      r_we         <= 1'b0;
      r_last_grant <= PORT_AUX;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_cnt        <= '0;
      r_p0_rdata   <= '0;
      r_p1_rdata   <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_gnt_valid) begin
          r_sel        <= w_gnt_idx;
          r_last_grant <= w_gnt_idx;
          r_we         <= w_gnt_idx ? bus.p1_we    : bus.p0_we;
          r_addr       <= w_gnt_idx ? bus.p1_addr  : bus.p0_addr;
          r_wdata      <= w_gnt_idx ? bus.p1_wdata : bus.p0_wdata;
          r_cnt        <= CNT_W'(WAIT_STATES);
        end
        ACCESS: begin
          if (!w_cnt_zero) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else if (!r_we) begin
            if (r_sel == PORT_AUX) r_p1_rdata <= bus.mem_rdata;
            else                   r_p0_rdata <= bus.mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_read  = w_mem_read;
  assign bus.mem_write = w_mem_write;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.p0_ready  = w_p0_ready;
  assign bus.p1_ready  = w_p1_ready;
  assign bus.p0_rdata  = r_p0_rdata;
  assign bus.p1_rdata  = r_p1_rdata;
  assign bus.busy      = (r_state != IDLE);
  assign bus.stall     = bus.p0_req & ~w_p0_ready;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed scoreboard bench for dmem_arbiter with WAIT_STATES = 1, 3 and 0 instances,
// each backed by a small word-indexed memory model.
module tb_dmem_arbiter;

  typedef struct {
    int          due;
    logic [31:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic rst3;
  int   cyc = 0;

  int checks   = 0;
  int failures = 0;

  exp_t q0[$];
  exp_t q1[$];

  logic        s_p0_ready, s_p1_ready, s_stall;
  int          s_cyc;
  int          wr_cnt1 = 0, wr_cnt3 = 0, rdy_cnt3 = 0, rd_cnt0 = 0;
  logic [31:0] wr_addr1, wr_data1;
  int          rdy_cyc0;
  logic [31:0] rdata0;

  dmem_arbiter_if #(.WORD_SIZE(32)) b1 ();
  dmem_arbiter_if #(.WORD_SIZE(32)) b3 ();
  dmem_arbiter_if #(.WORD_SIZE(32)) b0 ();

  dmem_arbiter #(.WORD_SIZE(32), .WAIT_STATES(1), .CNT_W(4)) u_dut1 (.clk(clk), .rst(rst),  .bus(b1));
  dmem_arbiter #(.WORD_SIZE(32), .WAIT_STATES(3), .CNT_W(4)) u_dut3 (.clk(clk), .rst(rst3), .bus(b3));
  dmem_arbiter #(.WORD_SIZE(32), .WAIT_STATES(0), .CNT_W(4)) u_dut0 (.clk(clk), .rst(rst),  .bus(b0));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Unwritten words read back a fixed address-derived pattern.
  function automatic logic [31:0] pat(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  logic [31:0] m1 [256];
  logic [31:0] m3 [256];
  logic [31:0] m0 [256];
  bit          v1 [256];
  bit          v3 [256];
  bit          v0 [256];

  assign b1.mem_rdata = v1[b1.mem_addr[9:2]] ? m1[b1.mem_addr[9:2]] : pat(b1.mem_addr);
  assign b3.mem_rdata = v3[b3.mem_addr[9:2]] ? m3[b3.mem_addr[9:2]] : pat(b3.mem_addr);
  assign b0.mem_rdata = v0[b0.mem_addr[9:2]] ? m0[b0.mem_addr[9:2]] : pat(b0.mem_addr);

  always @(posedge clk) if (b1.mem_write) begin m1[b1.mem_addr[9:2]] <= b1.mem_wdata; v1[b1.mem_addr[9:2]] <= 1'b1; end
  always @(posedge clk) if (b3.mem_write) begin m3[b3.mem_addr[9:2]] <= b3.mem_wdata; v3[b3.mem_addr[9:2]] <= 1'b1; end
  always @(posedge clk) if (b0.mem_write) begin m0[b0.mem_addr[9:2]] <= b0.mem_wdata; v0[b0.mem_addr[9:2]] <= 1'b1; end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: observe all instances on the falling edge, then return just after the next rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    s_cyc      = cyc;
    s_p0_ready = b1.p0_ready;
    s_p1_ready = b1.p1_ready;
    s_stall    = b1.stall;
    if (b1.mem_write) begin wr_cnt1++; wr_addr1 = b1.mem_addr; wr_data1 = b1.mem_wdata; end
    if (b1.p0_ready) begin
      if (q0.size() == 0) check("p0_spurious_ready", b1.p0_ready, 0);
      else begin
        e = q0.pop_front();
        check("p0_ready_cycle", cyc, e.due);
        check("p0_rdata", b1.p0_rdata, e.rdata);
      end
    end
    if (b1.p1_ready) begin
      if (q1.size() == 0) check("p1_spurious_ready", b1.p1_ready, 0);
      else begin
        e = q1.pop_front();
        check("p1_ready_cycle", cyc, e.due);
        check("p1_rdata", b1.p1_rdata, e.rdata);
      end
    end
    if (b3.mem_write) wr_cnt3++;
    if (b3.p0_ready || b3.p1_ready) rdy_cnt3++;
    if (b0.mem_read) rd_cnt0++;
    if (b0.p0_ready) begin rdy_cyc0 = cyc; rdata0 = b0.p0_rdata; end
    @(posedge clk);
    #1;
  endtask

  // Single transaction on the WAIT_STATES = 1 instance; ready is due WAIT_STATES + 2 cycles later.
  task automatic run_txn(input logic port, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rd, input string tag);
    int due;
    bit done;
    due = cyc + 3;
    if (port == 1'b0) begin
      b1.p0_we = we; b1.p0_addr = addr; b1.p0_wdata = wdata; b1.p0_req = 1'b1;
      q0.push_back('{due, exp_rd});
    end else begin
      b1.p1_we = we; b1.p1_addr = addr; b1.p1_wdata = wdata; b1.p1_req = 1'b1;
      q1.push_back('{due, exp_rd});
    end
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      tick();
      if (port == 1'b0) check({tag, "_stall"}, s_stall, (s_cyc == due) ? 0 : 1);
      done = port ? s_p1_ready : s_p0_ready;
    end
    if (port == 1'b0) b1.p0_req = 1'b0;
    else              b1.p1_req = 1'b0;
    check({tag, "_done"}, done, 1);
  endtask

  initial begin
    int          n0, n1, w, r, base;
    logic        rnd_req;
    logic [31:0] exp_rd0, exp_rd1;

    b3.p0_req = 0; b3.p0_we = 0; b3.p0_addr = 0; b3.p0_wdata = 0;
    b3.p1_req = 0; b3.p1_we = 0; b3.p1_addr = 0; b3.p1_wdata = 0;
    b0.p0_req = 0; b0.p0_we = 0; b0.p0_addr = 0; b0.p0_wdata = 0;
    b0.p1_req = 0; b0.p1_we = 0; b0.p1_addr = 0; b0.p1_wdata = 0;

    // Reset held two cycles with random requests on the main instance.
    rst = 1'b1; rst3 = 1'b1;
    rnd_req    = 1'($urandom_range(0, 1));
    b1.p0_req  = rnd_req;          b1.p0_we = 1'($urandom_range(0, 1));
    b1.p0_addr = $urandom();       b1.p0_wdata = $urandom();
    b1.p1_req  = 1'($urandom_range(0, 1)); b1.p1_we = 1'($urandom_range(0, 1));
    b1.p1_addr = $urandom();       b1.p1_wdata = $urandom();
    tick();
    tick();
    check("rst_p0_ready",  b1.p0_ready, 0);
    check("rst_p1_ready",  b1.p1_ready, 0);
    check("rst_mem_read",  b1.mem_read, 0);
    check("rst_mem_write", b1.mem_write, 0);
    check("rst_busy",      b1.busy, 0);
    check("rst_p0_rdata",  b1.p0_rdata, 0);
    check("rst_p1_rdata",  b1.p1_rdata, 0);
    check("rst_mem_addr",  b1.mem_addr, 0);
    check("rst_mem_wdata", b1.mem_wdata, 0);
    check("rst_stall",     b1.stall, rnd_req);
    b1.p0_req = 0; b1.p0_we = 0; b1.p0_addr = 0; b1.p0_wdata = 0;
    b1.p1_req = 0; b1.p1_we = 0; b1.p1_addr = 0; b1.p1_wdata = 0;
    rst = 1'b0; rst3 = 1'b0;
    tick();

    // Both ports request continuously: first tie goes to port 0, then strict alternation.
    base = cyc;
    exp_rd0 = pat(32'h10);
    exp_rd1 = pat(32'h20);
    b1.p0_we = 0; b1.p0_addr = 32'h10; b1.p0_req = 1;
    b1.p1_we = 0; b1.p1_addr = 32'h20; b1.p1_req = 1;
    q0.push_back('{base + 3,  exp_rd0});
    q1.push_back('{base + 7,  exp_rd1});
    q0.push_back('{base + 11, exp_rd0});
    q1.push_back('{base + 15, exp_rd1});
    n0 = 0; n1 = 0;
    for (int i = 0; i < 40 && (n0 < 2 || n1 < 2); i++) begin
      tick();
      if (s_p0_ready) n0++;
      if (s_p1_ready) n1++;
      if (n0 == 2) b1.p0_req = 0;
      if (n1 == 2) b1.p1_req = 0;
    end
    b1.p0_req = 0; b1.p1_req = 0;
    check("alt_p0_grants", n0, 2);
    check("alt_p1_grants", n1, 2);

    // p0 store then load back from the same address.
    w = wr_cnt1;
    run_txn(1'b0, 1'b1, 32'h100, 32'hDEADBEEF, exp_rd0, "p0_store");
    check("store_write_pulses", wr_cnt1 - w, 1);
    check("store_write_addr",   wr_addr1, 32'h100);
    check("store_write_data",   wr_data1, 32'hDEADBEEF);
    exp_rd0 = 32'hDEADBEEF;
    run_txn(1'b0, 1'b0, 32'h100, 32'h0, exp_rd0, "p0_load");

    // p1 store leaves p1_rdata alone; p0 then sees the stored word.
    w = wr_cnt1;
    run_txn(1'b1, 1'b1, 32'h200, 32'h11223344, exp_rd1, "p1_store");
    check("p1_store_write_pulses", wr_cnt1 - w, 1);
    exp_rd0 = 32'h11223344;
    run_txn(1'b0, 1'b0, 32'h200, 32'h0, exp_rd0, "p0_load_200");

    // WAIT_STATES = 3: reset lands in the second ACCESS cycle of a store.
    w = wr_cnt3; r = rdy_cnt3;
    b3.p0_we = 1; b3.p0_addr = 32'h300; b3.p0_wdata = 32'hCAFEF00D; b3.p0_req = 1;
    tick();
    tick();
    rst3 = 1'b1; b3.p0_req = 0;
    tick();
    check("ws3_idle_after_rst", b3.busy, 0);
    rst3 = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("ws3_no_write",  wr_cnt3 - w, 0);
    check("ws3_no_ready",  rdy_cnt3 - r, 0);
    check("ws3_mem_untouched", v3[8'hC0], 0);

    // WAIT_STATES = 0: load completes two cycles after the request.
    base = cyc; r = rd_cnt0; rdy_cyc0 = -1;
    b0.p0_we = 0; b0.p0_addr = 32'h40; b0.p0_req = 1;
    for (int i = 0; i < 10 && rdy_cyc0 < 0; i++) tick();
    b0.p0_req = 0;
    tick();
    tick();
    check("ws0_ready_cycle", rdy_cyc0, base + 2);
    check("ws0_rdata",       rdata0, pat(32'h40));
    check("ws0_read_pulses", rd_cnt0 - r, 1);

    check("p0_sb_empty", q0.size(), 0);
    check("p1_sb_empty", q1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
